sequential_alu: RTL and testbench
=================================

// Module: sequential_alu
// PURPOSE
//  Parametrised, handshaked ALU for the execute stage. Single-cycle logic/arith ops keep the
//  existing opcode map. Adds iterative unsigned MULTU/DIVU (one bit per cycle) with a HI
//  output, for which the pipeline stalls on busy.
//  Results, zero and status are registered; the hazard unit stalls on busy.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
//  OPW    4   opcode width
// PORTS
//  clock        in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high; clears all state and outputs
//  start        in   1      request; accepted only when ready=1
//  op           in   OPW    opcode, sampled on accept
//  a, b         in   WIDTH  operands, sampled on accept (may change afterwards)
//  ready        out  1      1 in IDLE only
//  busy         out  1      1 from cycle after accept until done cycle inclusive
//  done         out  1      one-cycle pulse: result/hi/zero/div_by_zero valid from now
//  result       out  WIDTH  low result (MULTU: product[WIDTH-1:0]; DIVU: quotient)
//  hi           out  WIDTH  MULTU: product[2*WIDTH-1:WIDTH]; DIVU: remainder; else 0
//  zero         out  1      registered (result == 0), updated with result
//  div_by_zero  out  1      set with done of a DIVU whose b==0; cleared on next accept
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, busy=0, done=0, result=0, hi=0, zero=1, div_by_zero=0, count=0.
//  Opcodes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLTU (result = {0..,a<b} unsigned), 12 NOR,
//   8 MULTU, 9 DIVU. Any other op: result=0, hi=0, single-cycle path.
//  ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
//  FSM: IDLE -> (start & single op) -> FIN; IDLE -> (start & MULTU/DIVU, b!=0 for DIVU) -> RUN;
//   IDLE -> (start & DIVU & b==0) -> FIN; RUN -> (count==WIDTH-1) -> FIN; FIN -> IDLE.
//   ready=1 only in IDLE; busy=1 in RUN and FIN.
//  Latency from accept edge: single-cycle ops and DIVU-by-zero: done 1 cycle later.
//   MULTU/DIVU: count 0..WIDTH-1 in RUN, done WIDTH+1 cycles after accept.
//  MULTU: shift-add over 2*WIDTH accumulator, LSB of multiplier first.
//  DIVU: restoring division, MSB first.
//  Div by zero: result = all ones, hi = a, div_by_zero=1.
//  start while not IDLE (incl. FIN) is ignored; no queuing.
//   Back-to-back throughput is one op per 2 cycles minimum.
//  result/hi/zero/div_by_zero hold their values between done and the next done.
//   They are not cleared on accept; div_by_zero is the exception and clears on accept.
//  Reset mid-RUN: operation aborted, no done pulse, outputs return to reset values.
//  zero/result/hi update in the same edge that raises done; never partial values visible.
// STRUCTURE
//  Package alu_pkg: localparams OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=6, OP_SLTU=7, OP_MULTU=8,
//   OP_DIVU=9, OP_NOR=12; state encoding IDLE=2'd0, RUN=2'd1, FIN=2'd2.
//  Sub-module seq_muldiv_core #(WIDTH): iterative datapath (accumulator, shifted operand,
//   counter) with load/step/last signals from the FSM.
//  Top: FSM, single-cycle combinational datapath, output registers.
// TESTING
//  1. WIDTH=32: ADD a=0xFFFFFFFF,b=1 -> done 1 cycle after accept, result=0, zero=1, hi=0.
//  2. SUB a=5,b=7 -> result=0xFFFFFFFE; SLTU a=5,b=7 -> 1; SLTU a=7,b=5 -> 0, zero=1.
//  3. MULTU a=0xFFFFFFFF,b=0xFFFFFFFF -> done exactly 33 cycles after accept,
//     hi=0xFFFFFFFE, result=0x00000001; busy=1 for those 33 cycles; start pulses mid-op ignored.
//  4. DIVU a=100,b=7 -> result=14, hi=2 after 33 cycles.
//     DIVU a=9,b=0 -> done after 1 cycle, result=0xFFFFFFFF, hi=9, div_by_zero=1.
//  5. Assert reset at RUN count=10 of a MULTU -> no done; all outputs at reset values.
//     ready=1 after release; next ADD 2+3 -> result=5.
//  6. Unused op=3 -> result=0, zero=1; rerun 1-4 with WIDTH=8 (MULTU 0xFF*0xFF -> hi=0xFE,
//     result=0x01, done 9 cycles after accept).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the sequential execute-stage ALU.

package alu_pkg;

   localparam int unsigned OP_AND   = 0;
   localparam int unsigned OP_OR    = 1;
   localparam int unsigned OP_ADD   = 2;
   localparam int unsigned OP_SUB   = 6;
   localparam int unsigned OP_SLTU  = 7;
   localparam int unsigned OP_MULTU = 8;
   localparam int unsigned OP_DIVU  = 9;
   localparam int unsigned OP_NOR   = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned multiply/divide datapath, one bit per step, sharing one 2*WIDTH accumulator.
// Multiply: shift-add, multiplier LSB first. Divide: restoring, dividend MSB first.

module seq_muldiv_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic [WIDTH-1:0] lo_next_o,
   output logic [WIDTH-1:0] hi_next_o
);

   localparam int unsigned CW = $clog2(WIDTH);

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [CW-1:0]      count_q, count_d;
   logic               div_q, div_d;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] step_acc;

   always_comb begin
      addend    = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd_q};
      // shift < 2*divisor always holds, so the borrow bit alone decides
      div_ge    = ~div_diff[WIDTH];

      if (div_q) begin
         step_acc = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
      end else begin
         step_acc = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      count_d = count_q;
      div_d   = div_q;
      if (load_i) begin
         acc_d   = {{WIDTH{1'b0}}, a_i};
         opnd_d  = b_i;
         count_d = '0;
         div_d   = div_i;
      end else if (step_i) begin
         acc_d   = step_acc;
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         opnd_q  <= '0;
         count_q <= '0;
         div_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         count_q <= count_d;
         div_q   <= div_d;
      end
   end

   assign last_o    = (count_q == CW'(WIDTH - 1));
   assign lo_next_o = step_acc[WIDTH-1:0];
   assign hi_next_o = step_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/sequential_alu.sv
// Handshaked execute-stage ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU.
// All outputs are registered and change only on the edge entering FIN (done) or on accept.

module sequential_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OPW   = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             div_by_zero
);

   state_e           state_q, state_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;
   logic             dbz_q, dbz_d;

   logic             is_mul, is_div, b_is_zero;
   logic [WIDTH-1:0] single_res;
   logic             core_load, core_step, core_last;
   logic [WIDTH-1:0] core_lo, core_hi;

   seq_muldiv_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clock    (clock),
      .reset    (reset),
      .load_i   (core_load),
      .step_i   (core_step),
      .div_i    (is_div),
      .a_i      (a),
      .b_i      (b),
      .last_o   (core_last),
      .lo_next_o(core_lo),
      .hi_next_o(core_hi)
   );

   always_comb begin
      is_mul    = (op == OPW'(OP_MULTU));
      is_div    = (op == OPW'(OP_DIVU));
      b_is_zero = (b == {WIDTH{1'b0}});

      single_res = '0;
      if (op == OPW'(OP_AND)) begin
         single_res = a & b;
      end else if (op == OPW'(OP_OR)) begin
         single_res = a | b;
      end else if (op == OPW'(OP_ADD)) begin
         single_res = a + b;
      end else if (op == OPW'(OP_SUB)) begin
         single_res = a - b;
      end else if (op == OPW'(OP_SLTU)) begin
         single_res = {{(WIDTH-1){1'b0}}, (a < b)};
      end else if (op == OPW'(OP_NOR)) begin
         single_res = ~(a | b);
      end
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      hi_d      = hi_q;
      dbz_d     = dbz_q;
      core_load = 1'b0;
      core_step = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               dbz_d = 1'b0;
               if (is_mul || (is_div && !b_is_zero)) begin
                  state_d   = RUN;
                  core_load = 1'b1;
               end else begin
                  // single-cycle ops and divide-by-zero resolve at accept
                  state_d = FIN;
                  if (is_div) begin
                     result_d = '1;
                     hi_d     = a;
                     dbz_d    = 1'b1;
                  end else begin
                     result_d = single_res;
                     hi_d     = '0;
                  end
               end
            end
         end
         RUN: begin
            core_step = 1'b1;
            if (core_last) begin
               state_d  = FIN;
               result_d = core_lo;
               hi_d     = core_hi;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      zero_d  = (result_d == {WIDTH{1'b0}});
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == FIN);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b1;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         zero_q   <= zero_d;
         dbz_q    <= dbz_d;
      end
   end

   assign ready       = ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign result      = result_q;
   assign hi          = hi_q;
   assign zero        = zero_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_alu.sv
// Directed self-checking bench for sequential_alu at WIDTH=32 and WIDTH=8.

module tb_sequential_alu;
   import alu_pkg::*;

   logic        clock = 1'b0;
   logic        reset;

   logic        start32, start8;
   logic [3:0]  op32, op8;
   logic [31:0] a32, b32;
   logic [7:0]  a8, b8;

   logic        ready32, busy32, done32, zero32, dbz32;
   logic [31:0] result32, hi32;
   logic        ready8, busy8, done8, zero8, dbz8;
   logic [7:0]  result8, hi8;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   sequential_alu #(.WIDTH(32), .OPW(4)) dut32 (
      .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
      .ready(ready32), .busy(busy32), .done(done32), .result(result32), .hi(hi32),
      .zero(zero32), .div_by_zero(dbz32)
   );

   sequential_alu #(.WIDTH(8), .OPW(4)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .ready(ready8), .busy(busy8), .done(done8), .result(result8), .hi(hi8),
      .zero(zero8), .div_by_zero(dbz8)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one op, wait for done (bounded), then check results and the one-cycle done pulse.
   task automatic run_check(input string tag, input bit w8, input logic [3:0] o,
                            input logic [31:0] av, input logic [31:0] bv, input bit inject,
                            input int exp_lat, input logic [31:0] exp_res,
                            input logic [31:0] exp_hi, input logic exp_z, input logic exp_dz);
      int          lat;
      int          busy_cnt;
      logic [31:0] res, hv;
      logic        z, dz;
      lat = -1; busy_cnt = 0; res = '0; hv = '0; z = 1'b0; dz = 1'b0;

      @(negedge clock);
      check_eq({tag, "_ready"}, w8 ? ready8 : ready32, 1'b1);
      if (w8) begin
         op8 = o; a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
      end else begin
         op32 = o; a32 = av; b32 = bv; start32 = 1'b1;
      end
      @(posedge clock);
      #1;
      start8 = 1'b0; start32 = 1'b0;
      a8 = ~a8; b8 = ~b8; a32 = ~a32; b32 = ~b32;

      for (int n = 1; n <= 40 && lat < 0; n++) begin
         @(negedge clock);
         if (w8 ? busy8 : busy32) busy_cnt++;
         if (w8 ? done8 : done32) begin
            lat = n;
            res = w8 ? {24'h0, result8} : result32;
            hv  = w8 ? {24'h0, hi8} : hi32;
            z   = w8 ? zero8 : zero32;
            dz  = w8 ? dbz8 : dbz32;
         end else if (inject && (n == 5 || n == 20)) begin
            check_eq({tag, "_ready_mid"}, w8 ? ready8 : ready32, 1'b0);
            op8 = 4'(OP_ADD); op32 = 4'(OP_ADD);
            if (w8) start8 = 1'b1;
            else start32 = 1'b1;
         end else begin
            start8 = 1'b0; start32 = 1'b0;
         end
      end
      start8 = 1'b0; start32 = 1'b0;

      check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
      check_eq({tag, "_result"}, res, exp_res);
      check_eq({tag, "_hi"}, hv, exp_hi);
      check_eq({tag, "_zero"}, z, exp_z);
      check_eq({tag, "_dbz"}, dz, exp_dz);

      @(negedge clock);
      check_eq({tag, "_done_pulse"}, w8 ? done8 : done32, 1'b0);
      check_eq({tag, "_ready_after"}, w8 ? ready8 : ready32, 1'b1);
      check_eq({tag, "_result_hold"}, w8 ? {24'h0, result8} : result32, exp_res);
   endtask

   initial begin
      int done_seen;
      reset = 1'b1;
      start32 = 1'b0; start8 = 1'b0;
      op32 = '0; op8 = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
      #2;
      check_eq("reset_ready", ready32, 1'b1);
      check_eq("reset_busy", busy32, 1'b0);
      check_eq("reset_done", done32, 1'b0);
      check_eq("reset_result", result32, 32'h0);
      check_eq("reset_hi", hi32, 32'h0);
      check_eq("reset_zero", zero32, 1'b1);
      check_eq("reset_dbz", dbz32, 1'b0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // WIDTH=32 single-cycle ops
      run_check("add32_wrap", 1'b0, 4'(OP_ADD), 32'hFFFF_FFFF, 32'h1, 1'b0, 1, 32'h0, 32'h0,
                1'b1, 1'b0);
      run_check("sub32", 1'b0, 4'(OP_SUB), 32'd5, 32'd7, 1'b0, 1, 32'hFFFF_FFFE, 32'h0,
                1'b0, 1'b0);
      run_check("sltu32_lt", 1'b0, 4'(OP_SLTU), 32'd5, 32'd7, 1'b0, 1, 32'h1, 32'h0, 1'b0, 1'b0);
      run_check("sltu32_ge", 1'b0, 4'(OP_SLTU), 32'd7, 32'd5, 1'b0, 1, 32'h0, 32'h0, 1'b1, 1'b0);
      run_check("and32", 1'b0, 4'(OP_AND), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1, 32'hF000_F000,
                32'h0, 1'b0, 1'b0);
      run_check("or32", 1'b0, 4'(OP_OR), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1, 32'hFFF0_FFF0,
                32'h0, 1'b0, 1'b0);
      run_check("nor32", 1'b0, 4'(OP_NOR), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1, 32'h000F_000F,
                32'h0, 1'b0, 1'b0);

      // WIDTH=32 iterative ops, with ignored start pulses during MULTU
      run_check("multu32", 1'b0, 4'(OP_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33,
                32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_check("divu32", 1'b0, 4'(OP_DIVU), 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2,
                1'b0, 1'b0);
      run_check("divu32_small", 1'b0, 4'(OP_DIVU), 32'd3, 32'd10, 1'b0, 33, 32'd0, 32'd3,
                1'b1, 1'b0);
      run_check("divu32_by0", 1'b0, 4'(OP_DIVU), 32'd9, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd9,
                1'b0, 1'b1);

      // Reset in the middle of a MULTU at count 10
      @(negedge clock);
      op32 = 4'(OP_MULTU); a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; start32 = 1'b1;
      @(posedge clock);
      #1;
      start32 = 1'b0;
      check_eq("abort_dbz_cleared", dbz32, 1'b0);
      check_eq("abort_busy", busy32, 1'b1);
      check_eq("abort_result_held", result32, 32'hFFFF_FFFF);
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check_eq("abort_ready", ready32, 1'b1);
      check_eq("abort_busy_clr", busy32, 1'b0);
      check_eq("abort_done", done32, 1'b0);
      check_eq("abort_result", result32, 32'h0);
      check_eq("abort_hi", hi32, 32'h0);
      check_eq("abort_zero", zero32, 1'b1);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      done_seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if (done32) done_seen++;
      end
      check_eq("abort_no_done", 64'(done_seen), 64'd0);
      run_check("add32_after_rst", 1'b0, 4'(OP_ADD), 32'd2, 32'd3, 1'b0, 1, 32'd5, 32'h0,
                1'b0, 1'b0);
      run_check("unused_op3", 1'b0, 4'd3, 32'd5, 32'd7, 1'b0, 1, 32'h0, 32'h0, 1'b1, 1'b0);

      // WIDTH=8 rerun
      run_check("add8_wrap", 1'b1, 4'(OP_ADD), 32'hFF, 32'h1, 1'b0, 1, 32'h0, 32'h0, 1'b1, 1'b0);
      run_check("sub8", 1'b1, 4'(OP_SUB), 32'd5, 32'd7, 1'b0, 1, 32'hFE, 32'h0, 1'b0, 1'b0);
      run_check("sltu8_lt", 1'b1, 4'(OP_SLTU), 32'd5, 32'd7, 1'b0, 1, 32'h1, 32'h0, 1'b0, 1'b0);
      run_check("sltu8_ge", 1'b1, 4'(OP_SLTU), 32'd7, 32'd5, 1'b0, 1, 32'h0, 32'h0, 1'b1, 1'b0);
      run_check("multu8", 1'b1, 4'(OP_MULTU), 32'hFF, 32'hFF, 1'b1, 9, 32'h01, 32'hFE,
                1'b0, 1'b0);
      run_check("multu8_lo", 1'b1, 4'(OP_MULTU), 32'h0F, 32'h11, 1'b0, 9, 32'hFF, 32'h00,
                1'b0, 1'b0);
      run_check("divu8", 1'b1, 4'(OP_DIVU), 32'd100, 32'd7, 1'b0, 9, 32'd14, 32'd2, 1'b0, 1'b0);
      run_check("divu8_by0", 1'b1, 4'(OP_DIVU), 32'd9, 32'd0, 1'b0, 1, 32'hFF, 32'd9,
                1'b0, 1'b1);
      run_check("unused8_op3", 1'b1, 4'd3, 32'd5, 32'd7, 1'b0, 1, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
